// File: rtl/crt_dot_renderer.sv
// crt_dot_renderer: draws a LINES x BITS dot/dash raster from the CRT store,
// fetching each store row one row ahead of the beam.
module crt_dot_renderer #(
  parameter int BITS     = 32,
  parameter int LINES    = 32,
  parameter int ADDR_W   = 5,
  parameter int CELL_W   = 16,
  parameter int CELL_H   = 16,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0,
  parameter int DOT_X0   = 4,
  parameter int DOT_X1   = 11,
  parameter int DASH_X0  = 1,
  parameter int DASH_X1  = 14,
  parameter int SHAPE_Y0 = 6,
  parameter int SHAPE_Y1 = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_valid,
  input  logic              blank,
  input  logic              invert,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BITS-1:0]   mem_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              fetch_miss
);

  localparam int XW = $clog2(CELL_W);
  localparam int YW = $clog2(CELL_H);
  localparam int CW = $clog2(BITS + 1);
  localparam int IW = $clog2(BITS);
  localparam int RW = $clog2(LINES + 1);
  localparam int PW = $clog2(X_ORIGIN + BITS * CELL_W + 2);
  localparam int LW = $clog2(Y_ORIGIN + LINES * CELL_H + 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [PW-1:0]   px_cnt;
  logic [XW-1:0]   cx;
  logic [CW-1:0]   col;
  logic [LW-1:0]   line_cnt;
  logic [YW-1:0]   cy;
  logic [RW-1:0]   row;
  logic            first_line;

  logic [LW-1:0]   nxt_line;
  logic [YW-1:0]   nxt_cy;
  logic [RW-1:0]   nxt_row;
  logic            row_begin;
  logic            x_in;
  logic            y_in;

  logic [0:0]      state;
  logic [BITS-1:0] active;
  logic [BITS-1:0] shadow;
  logic            shadow_full;
  logic            swap_issue;
  logic            issue;
  logic [ADDR_W-1:0] issue_addr;

  logic            s1_valid;
  logic            s1_in;
  logic            s1_blank;
  logic            s1_inv;
  logic [XW-1:0]   s1_cx;
  logic [YW-1:0]   s1_cy;
  logic [IW-1:0]   s1_col;

  logic            bit_sel;
  logic            y_hit;
  logic            dot_hit;
  logic            dash_hit;
  logic            lit;

  // first_line makes the next line_start scanline 0, whether or not
  // it coincides with frame_start
  always_comb begin
    nxt_line = line_cnt;
    nxt_cy   = cy;
    nxt_row  = row;
    if (frame_start || first_line) begin
      nxt_line = '0;
      nxt_cy   = '0;
      nxt_row  = '0;
    end else begin
      if (line_cnt != '1)
        nxt_line = line_cnt + LW'(1);
      if (int'(line_cnt) >= Y_ORIGIN) begin
        if (cy == YW'(CELL_H - 1)) begin
          nxt_cy = '0;
          if (int'(row) < LINES)
            nxt_row = row + RW'(1);
        end else begin
          nxt_cy = cy + YW'(1);
        end
      end
    end
  end

  assign row_begin = line_start
                  && int'(nxt_line) >= Y_ORIGIN
                  && nxt_cy == '0
                  && int'(nxt_row) < LINES;

  assign y_in = int'(line_cnt) >= Y_ORIGIN && int'(row) < LINES;
  assign x_in = int'(px_cnt) >= X_ORIGIN && int'(col) < BITS;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt   <= '0;
      cy         <= '0;
      row        <= '0;
      first_line <= 1'b1;
    end else if (line_start) begin
      line_cnt   <= nxt_line;
      cy         <= nxt_cy;
      row        <= nxt_row;
      first_line <= 1'b0;
    end else if (frame_start) begin
      line_cnt   <= '0;
      cy         <= '0;
      row        <= '0;
      first_line <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px_cnt <= '0;
      cx     <= '0;
      col    <= '0;
    end else if (line_start) begin
      px_cnt <= '0;
      cx     <= '0;
      col    <= '0;
    end else if (pix_valid) begin
      if (px_cnt != '1)
        px_cnt <= px_cnt + PW'(1);
      if (x_in) begin
        if (cx == XW'(CELL_W - 1)) begin
          cx  <= '0;
          col <= col + CW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end
    end
  end

  assign swap_issue = row_begin && int'(nxt_row) + 1 < LINES;
  assign issue      = frame_start || swap_issue;
  assign issue_addr = swap_issue ? ADDR_W'(nxt_row + RW'(1)) : '0;

  // later assignments win: a swap abandons the fetch, a new issue overrides both
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      fetch_miss  <= 1'b0;
    end else begin
      if (state == WAIT && mem_ack) begin
        shadow      <= mem_data;
        shadow_full <= 1'b1;
        mem_req     <= 1'b0;
        state       <= IDLE;
      end
      if (row_begin) begin
        if (shadow_full) begin
          active <= shadow;
        end else begin
          active     <= '0;
          fetch_miss <= 1'b1;
          mem_req    <= 1'b0;
          state      <= IDLE;
        end
        shadow_full <= 1'b0;
      end
      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= issue_addr;
        state    <= WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_blank <= 1'b0;
      s1_inv   <= 1'b0;
      s1_cx    <= '0;
      s1_cy    <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_in    <= x_in && y_in;
      s1_blank <= blank;
      s1_inv   <= invert;
      s1_cx    <= cx;
      s1_cy    <= cy;
      s1_col   <= col[IW-1:0];
    end
  end

  always_comb begin
    bit_sel  = active[s1_col];
    y_hit    = int'(s1_cy) >= SHAPE_Y0 && int'(s1_cy) <= SHAPE_Y1;
    dot_hit  = int'(s1_cx) >= DOT_X0 && int'(s1_cx) <= DOT_X1;
    dash_hit = int'(s1_cx) >= DASH_X0 && int'(s1_cx) <= DASH_X1;
    lit      = s1_in && y_hit && (bit_sel ? dash_hit : dot_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= s1_valid;
      pixel       <= s1_valid && !s1_blank && s1_in && (lit ^ s1_inv);
    end
  end

endmodule

// File: tb/tb_crt_dot_renderer.sv
// tb_crt_dot_renderer: scoreboard bench driving a default-geometry instance
// and a small-cell, offset-origin instance from one shared beam stream.
module tb_crt_dot_renderer;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic        pix_valid;
  logic        blank;
  logic        invert;

  logic        mem_req_a, mem_req_b;
  logic [4:0]  mem_addr_a, mem_addr_b;
  logic        mem_ack_a, mem_ack_b;
  logic [31:0] mem_data_a, mem_data_b;
  logic        pixel_a, pixel_b;
  logic        pixel_valid_a, pixel_valid_b;
  logic        fetch_miss_a, fetch_miss_b;

  logic        ack_a, ack_b, late_a;
  logic [31:0] data_a, data_b;
  int          blk_a, blk_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] expa [32];
  logic [31:0] expb [32];

  typedef struct {
    bit px;
    int t;
    int x;
    int y;
  } exp_t;

  exp_t qa [$];
  exp_t qb [$];
  int   qaddr [$];

  int   cyc;
  int   nchk;
  int   nfail;
  logic preq;
  logic [4:0] paddr;

  crt_dot_renderer u_a (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_valid   (pix_valid),
    .blank       (blank),
    .invert      (invert),
    .mem_req     (mem_req_a),
    .mem_addr    (mem_addr_a),
    .mem_ack     (mem_ack_a),
    .mem_data    (mem_data_a),
    .pixel       (pixel_a),
    .pixel_valid (pixel_valid_a),
    .fetch_miss  (fetch_miss_a)
  );

  crt_dot_renderer #(
    .CELL_W   (8),
    .CELL_H   (8),
    .X_ORIGIN (8),
    .DOT_X0   (2),
    .DOT_X1   (5),
    .DASH_X0  (0),
    .DASH_X1  (7),
    .SHAPE_Y0 (3),
    .SHAPE_Y1 (4)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_valid   (pix_valid),
    .blank       (blank),
    .invert      (invert),
    .mem_req     (mem_req_b),
    .mem_addr    (mem_addr_b),
    .mem_ack     (mem_ack_b),
    .mem_data    (mem_data_b),
    .pixel       (pixel_b),
    .pixel_valid (pixel_valid_b),
    .fetch_miss  (fetch_miss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_ack_a  = ack_a | late_a;
  assign mem_data_a = late_a ? 32'hFFFF_FFFF : data_a;
  assign mem_ack_b  = ack_b;
  assign mem_data_b = data_b;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // store model: acks one beat after seeing req unless the row is withheld
  always @(negedge clk) begin
    if (ack_a) ack_a = 1'b0;
    else if (mem_req_a && int'(mem_addr_a) != blk_a) begin
      ack_a  = 1'b1;
      data_a = mem_a[mem_addr_a];
    end
    if (ack_b) ack_b = 1'b0;
    else if (mem_req_b && int'(mem_addr_b) != blk_b) begin
      ack_b  = 1'b1;
      data_b = mem_b[mem_addr_b];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (pixel_valid_a) begin
      if (qa.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL a_extra_pixel: got pixel_valid, expected none");
      end else begin
        e = qa.pop_front();
        chk($sformatf("a_px x=%0d y=%0d", e.x, e.y), pixel_a, e.px);
        chk($sformatf("a_lat x=%0d", e.x), cyc - e.t, 2);
      end
    end else begin
      chk("a_idle_pixel", pixel_a, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (pixel_valid_b) begin
      if (qb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL b_extra_pixel: got pixel_valid, expected none");
      end else begin
        e = qb.pop_front();
        chk($sformatf("b_px x=%0d y=%0d", e.x, e.y), pixel_b, e.px);
        chk($sformatf("b_lat x=%0d", e.x), cyc - e.t, 2);
      end
    end else begin
      chk("b_idle_pixel", pixel_b, 0);
    end
  end

  // a new request is a rising req or an address change with req held high
  always @(negedge clk) begin
    if (mem_req_a && (!preq || mem_addr_a != paddr)) begin
      if (qaddr.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL extra_req: got addr %0d, expected no request",
                 mem_addr_a);
      end else begin
        chk("fetch_addr", mem_addr_a, qaddr.pop_front());
      end
    end
    preq  = mem_req_a;
    paddr = mem_addr_a;
  end

  function automatic bit model(input int x, input int y,
                               input logic [31:0] w, input bit inv,
                               input bit blk, input int cw, input int ch,
                               input int xo, input int dx0, input int dx1,
                               input int sx0, input int sx1,
                               input int sy0, input int sy1);
    int c;
    int px;
    int py;
    bit l;
    if (blk || x < xo || x >= xo + 32 * cw || y >= 32 * ch) return 1'b0;
    c  = (x - xo) / cw;
    px = (x - xo) % cw;
    py = y % ch;
    if (w[c]) l = px >= sx0 && px <= sx1;
    else      l = px >= dx0 && px <= dx1;
    l = l && py >= sy0 && py <= sy1;
    return l ^ inv;
  endfunction

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    qaddr.push_back(0);
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic line(input int y, input int npix, input bit inv,
                      input bit blk);
    logic [31:0] wa;
    logic [31:0] wb;
    exp_t e;
    wa = (y / 16 < 32) ? expa[y / 16] : 32'h0;
    wb = (y / 8 < 32) ? expb[y / 8] : 32'h0;
    @(negedge clk);
    line_start = 1'b1;
    if (y % 16 == 0 && y / 16 < 31) qaddr.push_back(y / 16 + 1);
    @(negedge clk);
    line_start = 1'b0;
    for (int x = 0; x < npix; x++) begin
      pix_valid = 1'b1;
      invert    = inv;
      blank     = blk;
      e.t = cyc;
      e.x = x;
      e.y = y;
      e.px = model(x, y, wa, inv, blk, 16, 16, 0, 4, 11, 1, 14, 6, 9);
      qa.push_back(e);
      e.px = model(x, y, wb, inv, blk, 8, 8, 8, 2, 5, 0, 7, 3, 4);
      qb.push_back(e);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    invert    = 1'b0;
    blank     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    nchk = 0;
    nfail = 0;
    reset = 1'b1;
    frame_start = 1'b0;
    line_start = 1'b0;
    pix_valid = 1'b0;
    blank = 1'b0;
    invert = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;
    late_a = 1'b0;
    data_a = '0;
    data_b = '0;
    blk_a = -1;
    blk_b = -1;
    preq = 1'b0;
    paddr = '0;
    for (int r = 0; r < 32; r++) begin
      mem_a[r] = 32'h8000_0003 ^ (r << 8);
      mem_b[r] = 32'hAAAA_AAAA;
    end
    mem_a[0] = 32'h0000_0001;
    mem_a[5] = 32'hFFFF_FFFF;
    for (int r = 0; r < 32; r++) begin
      expa[r] = mem_a[r];
      expb[r] = mem_b[r];
    end

    repeat (3) @(negedge clk);
    chk("rst_req_a", mem_req_a, 0);
    chk("rst_addr_a", mem_addr_a, 0);
    chk("rst_miss_a", fetch_miss_a, 0);
    chk("rst_pv_a", pixel_valid_a, 0);
    chk("rst_req_b", mem_req_b, 0);
    chk("rst_miss_b", fetch_miss_b, 0);
    reset = 1'b0;

    // frame 1: full fetch sequence, shapes, invert, margin, blank
    pulse_frame();
    for (int y = 0; y < 516; y++) begin
      if (y == 0 || y == 3 || y == 7) line(y, 530, 1'b0, 1'b0);
      else if (y == 11) line(y, 530, 1'b1, 1'b0);
      else if (y == 19) line(y, 530, 1'b1, 1'b1);
      else line(y, 0, 1'b0, 1'b0);
    end
    chk("f1_miss_a", fetch_miss_a, 0);
    chk("f1_miss_b", fetch_miss_b, 0);
    chk("f1_req_idle_a", mem_req_a, 0);

    // frame 2: row 5 withheld
    blk_a = 5;
    expa[5] = 32'h0;
    pulse_frame();
    for (int y = 0; y < 100; y++) begin
      if (y == 87) line(y, 530, 1'b0, 1'b0);
      else line(y, 0, 1'b0, 1'b0);
      if (y == 79) chk("miss_before_row5", fetch_miss_a, 0);
      if (y == 80) chk("miss_at_row5", fetch_miss_a, 1);
    end

    // mid-frame restart with row 0 withheld, then reset during WAIT
    blk_a = 0;
    pulse_frame();
    chk("miss_through_frame", fetch_miss_a, 1);
    chk("wait_req_a", mem_req_a, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_req_a", mem_req_a, 0);
    chk("rst_wait_miss_a", fetch_miss_a, 0);
    reset = 1'b0;
    @(negedge clk);
    late_a = 1'b1;
    @(negedge clk);
    late_a = 1'b0;
    repeat (2) @(negedge clk);

    expa[0] = 32'h0;
    expb[0] = 32'h0;
    for (int y = 0; y < 8; y++) begin
      if (y == 7) line(y, 530, 1'b0, 1'b0);
      else line(y, 0, 1'b0, 1'b0);
      if (y == 0) chk("late_ack_miss_a", fetch_miss_a, 1);
    end

    repeat (10) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qaddr_drained", qaddr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
